// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai_nm_filt_if.sv
`default_nettype none
// ============================================================================
//  Module   : gf180mcu_fd_sc_mcu9t5v0__oai_nm_filt_if
//  Brief    : Signal bundle for the filtered OAI cell: enable, grouped
//             inputs and the raw/filtered/change outputs.
//  Revision : 1.0  initial release
// ============================================================================
interface gf180mcu_fd_sc_mcu9t5v0__oai_nm_filt_if #(
    parameter int NGRP = 2,
    parameter int NIN  = 3
);
    logic                 EN;
    logic [NGRP*NIN-1:0]  A;
    logic                 ZN;
    logic                 ZN_RAW;
    logic                 CHG;

    // Stimulus side drives enable and inputs, observes results
    modport master (output EN, A, input ZN, ZN_RAW, CHG);
    // Cell side consumes enable and inputs, produces results
    modport slave  (input EN, A, output ZN, ZN_RAW, CHG);
endinterface
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai_nm_filt.sv
`default_nettype none
// ============================================================================
//  Module   : gf180mcu_fd_sc_mcu9t5v0__oai_nm_filt
//  Brief    : Registered NGRP x NIN OR-AND-INVERT with a FILT-cycle
//             deglitch filter on the output. ZN_RAW is the unfiltered
//             result of the registered inputs; ZN only follows it after
//             FILT consecutive enabled cycles of disagreement.
//  Revision : 1.0  initial release
// ============================================================================
module gf180mcu_fd_sc_mcu9t5v0__oai_nm_filt #(
    parameter int NGRP = 2,
    parameter int NIN  = 3,
    parameter int FILT = 3
) (
    input  wire logic CLK,
    input  wire logic RN,
    inout  wire       VDD,
    inout  wire       VSS,
    gf180mcu_fd_sc_mcu9t5v0__oai_nm_filt_if.slave bus
);
    localparam int             CW        = $clog2(FILT + 1);
    localparam logic [CW-1:0]  C_CNT_MAX = CW'(FILT - 1);

    typedef enum logic {
        STABLE = 1'b0,
        PEND   = 1'b1
    } state_t;

    // Supplies are only present for netlist compatibility
    wire w_unused_supply;
    assign w_unused_supply = VDD ^ VSS;

    logic [NGRP*NIN-1:0] a_q;
    logic [NGRP-1:0]     grp_or;
    logic                zn_raw;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q,   cnt_d;
    logic                zn_q,    zn_d;
    logic                chg_q,   chg_d;

    // Input stage samples every edge regardless of EN so ZN_RAW stays live
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) a_q <= '0;
        else     a_q <= bus.A;
    end

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        assign grp_or[g] = |a_q[g*NIN +: NIN];
    end

    // Any X in a_q propagates straight through to the raw result
    assign zn_raw = ~&grp_or;

    // Filter state, counter and registered outputs
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            zn_q    <= 1'b1;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zn_q    <= zn_d;
            chg_q   <= chg_d;
        end
    end

    // Next-state: an unknown compare falls into the counting path, so an X
    // result only reaches ZN once it has qualified for FILT cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        zn_d    = zn_q;
        chg_d   = 1'b0;
        if (bus.EN) begin
            if (zn_raw == zn_q) begin
                cnt_d   = '0;
                state_d = STABLE;
            end else if (cnt_q == C_CNT_MAX) begin
                zn_d    = zn_raw;
                cnt_d   = '0;
                chg_d   = 1'b1;
                state_d = STABLE;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                state_d = PEND;
            end
        end
    end

    assign bus.ZN     = zn_q;
    assign bus.ZN_RAW = zn_raw;
    assign bus.CHG    = chg_q;
endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__oai_nm_filt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gf180mcu_fd_sc_mcu9t5v0__oai_nm_filt
//  Brief    : Self-checking bench for the filtered OAI cell: vector table,
//             reset/FILT=1 sequences and an exhaustive pattern sweep.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gf180mcu_fd_sc_mcu9t5v0__oai_nm_filt;
    logic CLK;
    logic RN;
    wire  vdd = 1'b1;
    wire  vss = 1'b0;

    gf180mcu_fd_sc_mcu9t5v0__oai_nm_filt_if #(.NGRP(2), .NIN(3)) bus1 ();
    gf180mcu_fd_sc_mcu9t5v0__oai_nm_filt_if #(.NGRP(3), .NIN(2)) bus2 ();

    gf180mcu_fd_sc_mcu9t5v0__oai_nm_filt #(.NGRP(2), .NIN(3), .FILT(3)) dut1 (
        .CLK (CLK),
        .RN  (RN),
        .VDD (vdd),
        .VSS (vss),
        .bus (bus1)
    );

    gf180mcu_fd_sc_mcu9t5v0__oai_nm_filt #(.NGRP(3), .NIN(2), .FILT(1)) dut2 (
        .CLK (CLK),
        .RN  (RN),
        .VDD (vdd),
        .VSS (vss),
        .bus (bus2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0] a;
        logic       en;
        logic       zn;
        logic       raw;
        logic       chg;
    } vec_t;

    typedef struct {
        string name;
        logic  zn;
        logic  raw;
        logic  chg;
    } exp_t;

    localparam int NV = 31;
    vec_t vecs [NV];
    exp_t sbq [$];
    int   checks   = 0;
    int   failures = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic push(input string name, input logic zn, input logic raw, input logic chg);
        exp_t e;
        e.name = name;
        e.zn   = zn;
        e.raw  = raw;
        e.chg  = chg;
        sbq.push_back(e);
    endtask

    task automatic pop_check(input logic zn, input logic raw, input logic chg);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1");
        end else begin
            e = sbq.pop_front();
            chk({e.name, ".zn"},  zn,  e.zn);
            chk({e.name, ".raw"}, raw, e.raw);
            chk({e.name, ".chg"}, chg, e.chg);
        end
    endtask

    function automatic logic oai_ref(input logic [5:0] a);
        return !((a[2:0] != 3'b000) && (a[5:3] != 3'b000));
    endfunction

    initial begin
        // a, en, zn, raw, chg -- outputs expected after the edge
        vecs[0]  = '{6'b001_001, 1'b1, 1'b1, 1'b0, 1'b0}; // raw falls
        vecs[1]  = '{6'b001_001, 1'b1, 1'b1, 1'b0, 1'b0}; // cnt 1
        vecs[2]  = '{6'b001_001, 1'b1, 1'b1, 1'b0, 1'b0}; // cnt 2
        vecs[3]  = '{6'b001_001, 1'b1, 1'b0, 1'b0, 1'b1}; // qualifies
        vecs[4]  = '{6'b001_001, 1'b1, 1'b0, 1'b0, 1'b0}; // chg drops
        vecs[5]  = '{6'b000_000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{6'b000_000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{6'b000_000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{6'b000_000, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{6'b000_000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{6'b001_001, 1'b1, 1'b1, 1'b0, 1'b0}; // short glitch
        vecs[11] = '{6'b001_001, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{6'b000_001, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{6'b000_001, 1'b1, 1'b1, 1'b1, 1'b0}; // cnt cleared
        vecs[14] = '{6'b000_001, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{6'b001_001, 1'b1, 1'b1, 1'b0, 1'b0}; // pause test
        vecs[16] = '{6'b001_001, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{6'b001_001, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{6'b001_001, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{6'b001_001, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[20] = '{6'b001_001, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[21] = '{6'b001_001, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[22] = '{6'b001_001, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[23] = '{6'b001_001, 1'b1, 1'b0, 1'b0, 1'b1}; // resumes at 2
        vecs[24] = '{6'b001_001, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[25] = '{6'b000_000, 1'b0, 1'b0, 1'b1, 1'b0}; // raw live, EN=0
        vecs[26] = '{6'b000_000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[27] = '{6'b000_000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[28] = '{6'b000_000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[29] = '{6'b000_000, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[30] = '{6'b000_000, 1'b1, 1'b1, 1'b1, 1'b0};

        RN      = 1'b0;
        bus1.EN = 1'b0;
        bus1.A  = '0;
        bus2.EN = 1'b0;
        bus2.A  = '0;
        tick();
        tick();
        push("reset1", 1'b1, 1'b1, 1'b0);
        pop_check(bus1.ZN, bus1.ZN_RAW, bus1.CHG);
        push("reset2", 1'b1, 1'b1, 1'b0);
        pop_check(bus2.ZN, bus2.ZN_RAW, bus2.CHG);
        RN      = 1'b1;
        bus2.EN = 1'b1;

        // Vector table on the FILT=3 instance
        for (int i = 0; i < NV; i++) begin
            bus1.A  = vecs[i].a;
            bus1.EN = vecs[i].en;
            push($sformatf("vec%0d", i), vecs[i].zn, vecs[i].raw, vecs[i].chg);
            tick();
            pop_check(bus1.ZN, bus1.ZN_RAW, bus1.CHG);
        end

        // Reset during a pending rise: drive ZN low, then pend back up
        bus1.EN = 1'b1;
        bus1.A  = 6'b001_001;
        repeat (4) tick();
        push("rst_pre", 1'b0, 1'b0, 1'b1);
        pop_check(bus1.ZN, bus1.ZN_RAW, bus1.CHG);
        bus1.A = 6'b000_000;
        repeat (3) tick();
        push("rst_pend", 1'b0, 1'b1, 1'b0);
        pop_check(bus1.ZN, bus1.ZN_RAW, bus1.CHG);
        #2;
        RN = 1'b0;
        #1;
        push("rst_async", 1'b1, 1'b1, 1'b0);
        pop_check(bus1.ZN, bus1.ZN_RAW, bus1.CHG);
        bus1.A = 6'b001_001;
        #1;
        RN = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            push($sformatf("rst_after_e%0d", e), (e == 4) ? 1'b0 : 1'b1, 1'b0, (e == 4) ? 1'b1 : 1'b0);
            tick();
            pop_check(bus1.ZN, bus1.ZN_RAW, bus1.CHG);
        end

        // FILT=1 instance, three groups of two
        bus2.A = 6'b01_10_01;
        push("f1_araw", 1'b1, 1'b0, 1'b0);
        tick();
        pop_check(bus2.ZN, bus2.ZN_RAW, bus2.CHG);
        push("f1_fall", 1'b0, 1'b0, 1'b1);
        tick();
        pop_check(bus2.ZN, bus2.ZN_RAW, bus2.CHG);
        bus2.A = 6'b00_10_01;
        push("f1_araw2", 1'b0, 1'b1, 1'b0);
        tick();
        pop_check(bus2.ZN, bus2.ZN_RAW, bus2.CHG);
        push("f1_rise", 1'b1, 1'b1, 1'b1);
        tick();
        pop_check(bus2.ZN, bus2.ZN_RAW, bus2.CHG);
        push("f1_settle", 1'b1, 1'b1, 1'b0);
        tick();
        pop_check(bus2.ZN, bus2.ZN_RAW, bus2.CHG);

        // Exhaustive sweep, each pattern held FILT+1 edges
        bus1.EN = 1'b1;
        for (int p = 0; p < 64; p++) begin
            logic [5:0] pat;
            pat    = 6'(p);
            bus1.A = pat;
            repeat (4) tick();
            checks++;
            if (bus1.ZN !== oai_ref(pat) || bus1.ZN_RAW !== oai_ref(pat)) begin
                failures++;
                $display("FAIL sweep_%02h actual=zn%b/raw%b required=%b", pat, bus1.ZN, bus1.ZN_RAW, oai_ref(pat));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
